// File: rtl/tinyalu_serial_pkg.sv
// Shared types, constants and word helpers for the TinyALU serial link.
package tinyalu_serial_pkg;

  localparam int unsigned WORD_BITS     = 10;
  localparam int unsigned RESP_WORDS    = 3;
  localparam int unsigned RESP_BITS     = WORD_BITS * RESP_WORDS;

  localparam int unsigned ST_BIT_ANY    = 7;
  localparam int unsigned ST_BIT_DATA   = 2;
  localparam int unsigned ST_BIT_OP     = 1;
  localparam int unsigned ST_BIT_PARITY = 0;

  typedef enum logic {
    PL_DATA = 1'b0,
    PL_CMD  = 1'b1
  } payload_t;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_MUL = 3'b101
  } op_t;

  typedef enum logic [1:0] {
    ST_RX,
    ST_EXEC,
    ST_TX
  } state_t;

  typedef struct packed {
    logic data;
    logic op;
    logic parity;
  } err_t;

  // Even parity over payload bit and data (word bits 9..1).
  function automatic logic word_parity(input logic [WORD_BITS-1:0] w);
    return ^(w >> 1);
  endfunction

  // Build a complete word {payload, data, parity}.
  function automatic logic [WORD_BITS-1:0] make_word(input logic pl, input logic [7:0] d);
    logic [WORD_BITS-1:0] w;
    w    = {pl, d, 1'b0};
    w[0] = word_parity(w);
    return w;
  endfunction

endpackage

// File: rtl/tinyalu_serial_responder_word_rx.sv
// Serial word receiver: shifts in 10-bit words MSB first, flags completion for one cycle.
module tinyalu_word_rx
  import tinyalu_serial_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       enable_n_i,
  input  logic       din_i,
  output logic       word_done_o,
  output payload_t   payload_o,
  output logic [7:0] data_o,
  output logic       parity_ok_o
);

  localparam int unsigned CNT_W = 4;

  logic [WORD_BITS-2:0] shift_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WORD_BITS-1:0] word_c;

  // Current shift contents plus the bit being sampled this edge.
  assign word_c = {shift_q, din_i};

  // Shift/count while enabled; a gap in enable_n or leaving RX drops the partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      word_done_o <= 1'b0;
      payload_o   <= PL_DATA;
      data_o      <= '0;
      parity_ok_o <= 1'b0;
    end else begin
      word_done_o <= 1'b0;
      if (!en_i || enable_n_i) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(WORD_BITS - 1)) begin
        cnt_q       <= '0;
        word_done_o <= 1'b1;
        payload_o   <= payload_t'(word_c[9]);
        data_o      <= word_c[8:1];
        parity_ok_o <= (word_parity(word_c) == word_c[0]);
      end else begin
        shift_q <= word_c[WORD_BITS-2:0];
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tinyalu_serial_responder.sv
// DUT-side TinyALU serial endpoint: collects A, B, CMD; executes; returns status/MSB/LSB words.
module tinyalu_serial_responder
  import tinyalu_serial_pkg::*;
#(
  parameter int unsigned EXEC_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_n,
  input  logic din,
  output logic dout,
  output logic dout_valid
);

  localparam int unsigned LAT_W = 4;
  localparam int unsigned TX_W  = 5;

  state_t               state_q;
  logic [1:0]           wcnt_q;
  err_t                 err_q;
  err_t                 err_d;
  logic [7:0]           a_q;
  logic [7:0]           b_q;
  logic [LAT_W-1:0]     lat_q;
  logic [TX_W-1:0]      tx_q;
  logic [RESP_BITS-1:0] frame_q;
  logic [RESP_BITS-1:0] frame_c;
  logic [7:0]           status_c;
  logic [15:0]          result_c;

  logic       rx_done;
  payload_t   rx_payload;
  logic [7:0] rx_data;
  logic       rx_parity_ok;

  tinyalu_word_rx u_word_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (state_q == ST_RX),
    .enable_n_i  (enable_n),
    .din_i       (din),
    .word_done_o (rx_done),
    .payload_o   (rx_payload),
    .data_o      (rx_data),
    .parity_ok_o (rx_parity_ok)
  );

  // 8-bit operation with 16-bit result; SUB wraps to sign-extended two's complement.
  function automatic logic [15:0] alu(input op_t op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_AND:  return {8'h00, a & b};
      OP_OR:   return {8'h00, a | b};
      OP_XOR:  return {8'h00, a ^ b};
      OP_ADD:  return 16'(a) + 16'(b);
      OP_SUB:  return 16'(a) - 16'(b);
      OP_MUL:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // Error flags including whatever the word completing this cycle contributes.
  always_comb begin
    err_d = err_q;
    if (rx_done) begin
      if (!rx_parity_ok) err_d.parity = 1'b1;
      if (rx_payload == PL_DATA) begin
        if (wcnt_q >= 2'd2) err_d.data = 1'b1;
      end else begin
        if (wcnt_q != 2'd2) err_d.data = 1'b1;
        if (rx_data[2:0] inside {3'b110, 3'b111}) err_d.op = 1'b1;
      end
    end
  end

  // Response frame assembled at command time: status, result MSB, result LSB.
  always_comb begin
    status_c                = '0;
    status_c[ST_BIT_ANY]    = |err_d;
    status_c[ST_BIT_DATA]   = err_d.data;
    status_c[ST_BIT_OP]     = err_d.op;
    status_c[ST_BIT_PARITY] = err_d.parity;
    result_c                = (|err_d) ? 16'h0000 : alu(op_t'(rx_data[2:0]), a_q, b_q);
    frame_c                 = {make_word(PL_DATA, status_c),
                               make_word(PL_DATA, result_c[15:8]),
                               make_word(PL_DATA, result_c[7:0])};
  end

  // Control FSM RX -> EXEC -> TX with registered serial output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RX;
      wcnt_q     <= '0;
      err_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      lat_q      <= '0;
      tx_q       <= '0;
      frame_q    <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      case (state_q)
        ST_RX: begin
          if (rx_done) begin
            err_q <= err_d;
            if (rx_payload == PL_DATA) begin
              if (wcnt_q == 2'd0) a_q <= rx_data;
              if (wcnt_q == 2'd1) b_q <= rx_data;
              if (wcnt_q != 2'd3) wcnt_q <= wcnt_q + 2'd1;
            end else begin
              frame_q <= frame_c;
              lat_q   <= '0;
              state_q <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (lat_q == LAT_W'(EXEC_LATENCY - 1)) begin
            state_q    <= ST_TX;
            tx_q       <= '0;
            dout       <= frame_q[RESP_BITS-1];
            dout_valid <= 1'b1;
            frame_q    <= {frame_q[RESP_BITS-2:0], 1'b0};
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        ST_TX: begin
          if (tx_q == TX_W'(RESP_BITS - 1)) begin
            state_q    <= ST_RX;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            wcnt_q     <= '0;
            err_q      <= '0;
          end else begin
            tx_q    <= tx_q + TX_W'(1);
            dout    <= frame_q[RESP_BITS-1];
            frame_q <= {frame_q[RESP_BITS-2:0], 1'b0};
          end
        end
        default: state_q <= ST_RX;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_serial_responder.sv
// Self-checking bench for tinyalu_serial_responder: directed frames against a frame-level model.
module tb_tinyalu_serial_responder;

  localparam int L = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable_n = 1'b1;
  logic din = 1'b0;
  logic dout;
  logic dout_valid;

  int errors = 0;
  int checks = 0;

  int m_pl[$];
  int m_d[$];
  int m_bad[$];

  tinyalu_serial_responder #(.EXEC_LATENCY(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_n   (enable_n),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic par9(input logic [8:0] v);
    logic p = 1'b0;
    for (int i = 0; i < 9; i++) p ^= v[i];
    return p;
  endfunction

  function automatic logic [9:0] wordf(input logic [7:0] b);
    return {1'b0, b, par9({1'b0, b})};
  endfunction

  // Expected 30-bit response for the words sent since the last frame.
  function automatic logic [29:0] model_resp();
    int nd = 0;
    int a = 0;
    int b = 0;
    int op = 0;
    int res = 0;
    bit ed = 0;
    bit eo = 0;
    bit ep = 0;
    logic [7:0] st;
    foreach (m_pl[i]) begin
      if (m_bad[i] != 0) ep = 1;
      if (m_pl[i] == 0) begin
        if (nd == 0) a = m_d[i];
        else if (nd == 1) b = m_d[i];
        else ed = 1;
        nd++;
      end else begin
        if (nd != 2) ed = 1;
        op = m_d[i] % 8;
        if (op > 5) eo = 1;
      end
    end
    case (op)
      0: res = a & b;
      1: res = a | b;
      2: res = a ^ b;
      3: res = a + b;
      4: res = (a - b) & 'hFFFF;
      5: res = a * b;
      default: res = 0;
    endcase
    if (ed || eo || ep) res = 0;
    st = {(ed || eo || ep), 4'b0000, ed, eo, ep};
    return {wordf(st), wordf(8'(res >> 8)), wordf(8'(res))};
  endfunction

  task automatic clear_model();
    m_pl.delete();
    m_d.delete();
    m_bad.delete();
  endtask

  // Drive one full word; outputs must stay idle while receiving.
  task automatic send_word(input bit pl, input logic [7:0] d, input bit flip);
    logic [9:0] w;
    w = {pl, d, par9({pl, d}) ^ flip};
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      chk("rx idle", {30'd0, dout_valid, dout}, 32'd0);
      enable_n = 1'b0;
      din = w[i];
    end
    m_pl.push_back(int'(pl));
    m_d.push_back(int'(d));
    m_bad.push_back(int'(flip));
  endtask

  // Drive only the first nbits of a word; not recorded in the model.
  task automatic send_partial(input logic [7:0] d, input int nbits);
    logic [9:0] w;
    w = {1'b0, d, par9({1'b0, d})};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      enable_n = 1'b0;
      din = w[9 - i];
    end
  endtask

  // Check the whole response timeline after the last command bit, then the decoded bytes.
  task automatic finish_frame(input string name, input logic [7:0] exp_st, input logic [15:0] exp_res);
    logic [29:0] exp_bits;
    logic [29:0] got;
    int k;
    exp_bits = model_resp();
    clear_model();
    got = '0;
    for (int j = 1; j <= L + 32; j++) begin
      @(negedge clk);
      if (j == 1) begin
        enable_n = 1'b1;
        din = 1'b0;
      end
      if (j <= L + 1 || j == L + 32) begin
        chk($sformatf("%s idle j=%0d", name, j), {30'd0, dout_valid, dout}, 32'd0);
      end else begin
        k = j - L - 2;
        chk($sformatf("%s valid k=%0d", name, k), {31'd0, dout_valid}, 32'd1);
        chk($sformatf("%s bit k=%0d", name, k), {31'd0, dout}, {31'd0, exp_bits[29 - k]});
        got[29 - k] = dout;
      end
    end
    chk($sformatf("%s status word", name), {22'd0, got[29:20]}, {22'd0, wordf(exp_st)});
    chk($sformatf("%s msb word", name), {22'd0, got[19:10]}, {22'd0, wordf(exp_res[15:8])});
    chk($sformatf("%s lsb word", name), {22'd0, got[9:0]}, {22'd0, wordf(exp_res[7:0])});
  endtask

  task automatic frame3(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] cmd, input logic [7:0] exp_st, input logic [15:0] exp_res);
    send_word(1'b0, a, 1'b0);
    send_word(1'b0, b, 1'b0);
    send_word(1'b1, cmd, 1'b0);
    finish_frame(name, exp_st, exp_res);
  endtask

  initial begin
    logic [29:0] exp_bits;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset outputs", {30'd0, dout_valid, dout}, 32'd0);
    rst_n = 1'b1;

    // Reset during a partially received word; next frame must be clean
    send_partial(8'h12, 6);
    @(negedge clk);
    rst_n = 1'b0;
    enable_n = 1'b1;
    #1;
    chk("reset mid-word", {30'd0, dout_valid, dout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    frame3("add after reset", 8'h12, 8'h34, 8'h03, 8'h00, 16'h0046);

    // Main operations
    frame3("add", 8'h12, 8'h34, 8'h03, 8'h00, 16'h0046);
    frame3("mul", 8'hFF, 8'hFF, 8'h05, 8'h00, 16'hFE01);
    frame3("sub", 8'h01, 8'h02, 8'h04, 8'h00, 16'hFFFF);
    frame3("or", 8'hA0, 8'h05, 8'h01, 8'h00, 16'h00A5);
    frame3("xor", 8'hFF, 8'h0F, 8'hFA, 8'h00, 16'h00F0);
    frame3("add carry", 8'hFF, 8'h01, 8'h03, 8'h00, 16'h0100);

    // Parity errors, then recovery
    send_word(1'b0, 8'h12, 1'b1);
    send_word(1'b0, 8'h34, 1'b1);
    send_word(1'b1, 8'h03, 1'b0);
    finish_frame("parity err", 8'h81, 16'h0000);
    frame3("clean after parity", 8'h12, 8'h34, 8'h03, 8'h00, 16'h0046);

    // Frame structure and opcode errors
    send_word(1'b0, 8'h12, 1'b0);
    send_word(1'b1, 8'h03, 1'b0);
    finish_frame("one data", 8'h84, 16'h0000);
    frame3("bad op", 8'h12, 8'h34, 8'h07, 8'h82, 16'h0000);
    send_word(1'b0, 8'h12, 1'b0);
    send_word(1'b0, 8'h34, 1'b0);
    send_word(1'b0, 8'h56, 1'b0);
    send_word(1'b1, 8'h03, 1'b0);
    finish_frame("three data", 8'h84, 16'h0000);

    // enable_n abort mid-word, then a full AND frame
    send_partial(8'hF0, 4);
    @(negedge clk);
    enable_n = 1'b1;
    @(negedge clk);
    frame3("and after abort", 8'hF0, 8'h3C, 8'h00, 8'h00, 16'h0030);

    // Asynchronous reset at TX cycle 12
    send_word(1'b0, 8'h12, 1'b0);
    send_word(1'b0, 8'h34, 1'b0);
    send_word(1'b1, 8'h03, 1'b0);
    exp_bits = model_resp();
    clear_model();
    for (int j = 1; j <= L + 2 + 12; j++) begin
      @(negedge clk);
      if (j == 1) begin
        enable_n = 1'b1;
        din = 1'b0;
      end
      if (j >= L + 2) begin
        chk($sformatf("pre-reset valid j=%0d", j), {31'd0, dout_valid}, 32'd1);
        chk($sformatf("pre-reset bit j=%0d", j), {31'd0, dout}, {31'd0, exp_bits[29 - (j - L - 2)]});
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset in tx", {30'd0, dout_valid, dout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      chk($sformatf("post-reset idle j=%0d", j), {30'd0, dout_valid, dout}, 32'd0);
    end
    frame3("add after tx reset", 8'h12, 8'h34, 8'h03, 8'h00, 16'h0046);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
